haz_ctrl_unit: RTL and testbench

- Parametrised hazard and control unit for the 5-stage in-order pipeline (IF/ID/EX/MEM/WB).
- Detects load-use and RAW hazards, multi-cycle EX occupancy, and taken-branch redirects.
- Drives stage enables, flushes and operand forwarding selects.
- Holds a small FSM for multi-cycle stalls/flush windows, plus saturating performance counters.

---
 rtl/haz_ctrl_unit_pkg.sv | 21 ++
 rtl/haz_ctrl_unit_if.sv | 35 +++
 rtl/haz_fwd_sel.sv | 25 ++
 rtl/haz_ctrl_unit.sv | 185 ++++++++++++++++++
 tb/tb_haz_ctrl_unit.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/haz_ctrl_unit_pkg.sv
// Shared types for the hazard/control unit: FSM states, forwarding selects,
// and the window down-counter width.
package haz_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    LSTALL = 2'd1,
    FLUSH  = 2'd2,
    MCWAIT = 2'd3
  } haz_state_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  // Wide enough for LOAD_LAT-1 / FLUSH_CYC-1 up to 6.
  localparam int DCNT_W = 3;

endpackage

// File: rtl/haz_ctrl_unit_if.sv
// Pipeline <-> hazard unit bundle. master = pipeline datapath, slave = hazard unit.
interface haz_ctrl_unit_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  logic [REG_AW-1:0] id_rs1, id_rs2;
  logic              id_rs1_used, id_rs2_used;
  logic [REG_AW-1:0] ex_rs1, ex_rs2, ex_rd;
  logic              ex_wen, ex_is_load;
  logic [REG_AW-1:0] mem_rd, wb_rd;
  logic              mem_wen, wb_wen;
  logic              br_taken, mc_busy;

  logic              pc_en, if_id_en, id_ex_en, ex_mem_en;
  logic              if_id_flush, id_ex_flush;
  logic [1:0]        fwd_a, fwd_b;
  logic              haz;
  logic [CNT_W-1:0]  stall_cycles, flush_cycles;

  modport master (
    output id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           ex_rs1, ex_rs2, ex_rd, ex_wen, ex_is_load,
           mem_rd, wb_rd, mem_wen, wb_wen, br_taken, mc_busy,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush,
           fwd_a, fwd_b, haz, stall_cycles, flush_cycles
  );

  modport slave (
    input  id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           ex_rs1, ex_rs2, ex_rd, ex_wen, ex_is_load,
           mem_rd, wb_rd, mem_wen, wb_wen, br_taken, mc_busy,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush,
           fwd_a, fwd_b, haz, stall_cycles, flush_cycles
  );
endinterface

// File: rtl/haz_fwd_sel.sv
// Forwarding select for one EX operand: youngest producer (MEM) wins over WB;
// x0 is never forwarded.
module haz_fwd_sel
  import haz_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              mem_wen,
  input  logic              wb_wen,
  output fwd_sel_e          sel
);

  // Priority compare against the two in-flight destinations.
  always_comb begin
    sel = FWD_RF;
    if (mem_wen && (mem_rd != '0) && (mem_rd == src))
      sel = FWD_MEM;
    else if (wb_wen && (wb_rd != '0) && (wb_rd == src))
      sel = FWD_WB;
  end

endmodule

// File: rtl/haz_ctrl_unit.sv
// Hazard and control unit for the 5-stage in-order pipeline.
// Build option FWD_EN: defined -> EX operand forwarding, only load-use stalls
// (held LOAD_LAT cycles). Undefined -> no forwarding, any EX/MEM producer of a
// used ID source stalls, re-evaluated each cycle.
module haz_ctrl_unit
  import haz_pkg::*;
#(
  parameter int REG_AW    = 5,
  parameter int LOAD_LAT  = 1,
  parameter int FLUSH_CYC = 1,
  parameter int CNT_W     = 32
) (
  input logic       clk,
  input logic       reset,
  haz_ctrl_unit_if.slave hif
);

  localparam logic [DCNT_W-1:0] LD_RELOAD = DCNT_W'(LOAD_LAT - 1);
  localparam logic [DCNT_W-1:0] FL_RELOAD = DCNT_W'(FLUSH_CYC - 1);

  haz_state_e        state, state_n;
  logic [DCNT_W-1:0] cnt, cnt_n;
  logic              hit_ex, lu_hit, flush_br;
  logic              pc_en, if_id_en, id_ex_en, ex_mem_en;
  logic              if_id_flush, id_ex_flush, haz;
  logic [CNT_W-1:0]  stall_q, flush_q;
  fwd_sel_e          sel_a, sel_b;

  // A used, nonzero ID source that the EX instruction is about to write.
  always_comb begin
    hit_ex = hif.ex_wen && (hif.ex_rd != '0) &&
             ((hif.id_rs1_used && (hif.id_rs1 == hif.ex_rd)) ||
              (hif.id_rs2_used && (hif.id_rs2 == hif.ex_rd)));
  end

`ifdef FWD_EN
  localparam bit FWD_ON    = 1'b1;
  localparam bit LSTALL_ON = (LOAD_LAT > 1);

  // With forwarding only a load result arrives too late for the ID consumer.
  assign lu_hit = hit_ex && hif.ex_is_load;
`else
  localparam bit FWD_ON    = 1'b0;
  localparam bit LSTALL_ON = 1'b0;

  logic hit_mem;

  // Without forwarding both EX and MEM producers must drain; WB is covered by
  // the write-before-read regfile. Loads and ALU ops stall alike.
  always_comb begin
    hit_mem = hif.mem_wen && (hif.mem_rd != '0) &&
              ((hif.id_rs1_used && (hif.id_rs1 == hif.mem_rd)) ||
               (hif.id_rs2_used && (hif.id_rs2 == hif.mem_rd)));
  end

  assign lu_hit = (hit_ex && hif.ex_is_load) || (hit_ex && !hif.ex_is_load) || hit_mem;
`endif

  // Forwarding selects; write enables gated off when forwarding is built out.
  haz_fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
    .src    (hif.ex_rs1),
    .mem_rd (hif.mem_rd),
    .wb_rd  (hif.wb_rd),
    .mem_wen(hif.mem_wen && FWD_ON),
    .wb_wen (hif.wb_wen && FWD_ON),
    .sel    (sel_a)
  );

  haz_fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
    .src    (hif.ex_rs2),
    .mem_rd (hif.mem_rd),
    .wb_rd  (hif.wb_rd),
    .mem_wen(hif.mem_wen && FWD_ON),
    .wb_wen (hif.wb_wen && FWD_ON),
    .sel    (sel_b)
  );

  // FSM state and window down-counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next state and stage controls; branch > flush window > mc_busy > load-use.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    id_ex_en    = 1'b1;
    ex_mem_en   = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    haz         = 1'b0;
    flush_br    = 1'b0;
    if (reset) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_en    = 1'b0;
      ex_mem_en   = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      state_n     = RUN;
      cnt_n       = '0;
    end else if (hif.br_taken) begin
      // Redirect: PC loads the target, younger stages squashed; aborts LSTALL.
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      haz         = 1'b1;
      flush_br    = 1'b1;
      if (FLUSH_CYC > 1) begin
        state_n = FLUSH;
        cnt_n   = FL_RELOAD;
      end else begin
        state_n = RUN;
        cnt_n   = '0;
      end
    end else if (state == FLUSH) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      haz         = 1'b1;
      flush_br    = 1'b1;
      cnt_n       = cnt - 1'b1;
      if (cnt <= 1) state_n = RUN;
    end else if (hif.mc_busy) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      haz       = 1'b1;
      state_n   = MCWAIT;
      cnt_n     = '0;
    end else if (state == LSTALL) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
      haz         = 1'b1;
      cnt_n       = cnt - 1'b1;
      if (cnt <= 1) state_n = RUN;
    end else if (lu_hit) begin
      // RUN, or MCWAIT releasing this cycle, both evaluate like RUN.
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
      haz         = 1'b1;
      if (LSTALL_ON) begin
        state_n = LSTALL;
        cnt_n   = LD_RELOAD;
      end else begin
        state_n = RUN;
      end
    end else begin
      state_n = RUN;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_en && (stall_q != '1)) stall_q <= stall_q + 1'b1;
      if (flush_br && (flush_q != '1)) flush_q <= flush_q + 1'b1;
    end
  end

  assign hif.pc_en        = pc_en;
  assign hif.if_id_en     = if_id_en;
  assign hif.id_ex_en     = id_ex_en;
  assign hif.ex_mem_en    = ex_mem_en;
  assign hif.if_id_flush  = if_id_flush;
  assign hif.id_ex_flush  = id_ex_flush;
  assign hif.haz          = haz;
  assign hif.fwd_a        = reset ? FWD_RF : sel_a;
  assign hif.fwd_b        = reset ? FWD_RF : sel_b;
  assign hif.stall_cycles = stall_q;
  assign hif.flush_cycles = flush_q;

endmodule

// File: tb/tb_haz_ctrl_unit.sv
// Directed bench for haz_ctrl_unit (LOAD_LAT=2, FLUSH_CYC=2, CNT_W=4).
// Expectations follow the FWD_EN build option of the compile.
module tb_haz_ctrl_unit;
  localparam int AW = 5;
  localparam int CW = 4;
`ifdef FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  // {0, pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, haz}
  localparam logic [7:0] C_RST = 8'b0_0000_11_0;
  localparam logic [7:0] C_RUN = 8'b0_1111_00_0;
  localparam logic [7:0] C_BR  = 8'b0_1111_11_1;
  localparam logic [7:0] C_MC  = 8'b0_0000_00_1;
  localparam logic [7:0] C_LU  = 8'b0_0011_01_1;

  logic clk = 1'b0;
  logic reset;
  int   nvec = 0;
  int   nerr = 0;

  haz_ctrl_unit_if #(.REG_AW(AW), .CNT_W(CW)) bus ();

  haz_ctrl_unit #(.REG_AW(AW), .LOAD_LAT(2), .FLUSH_CYC(2), .CNT_W(CW)) dut (
    .clk  (clk),
    .reset(reset),
    .hif  (bus)
  );

  always #5 clk = ~clk;

  wire [7:0] ctl   = {1'b0, bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en,
                      bus.if_id_flush, bus.id_ex_flush, bus.haz};
  wire [7:0] fa    = {6'b0, bus.fwd_a};
  wire [7:0] fb    = {6'b0, bus.fwd_b};
  wire [7:0] stc   = {4'b0, bus.stall_cycles};
  wire [7:0] flc   = {4'b0, bus.flush_cycles};

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_rs1_used = 0; bus.id_rs2_used = 0;
    bus.ex_rs1 = '0; bus.ex_rs2 = '0; bus.ex_rd = '0; bus.ex_wen = 0; bus.ex_is_load = 0;
    bus.mem_rd = '0; bus.wb_rd = '0; bus.mem_wen = 0; bus.wb_wen = 0;
    bus.br_taken = 0; bus.mc_busy = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic load_use();
    bus.ex_is_load = 1; bus.ex_wen = 1; bus.ex_rd = 5'd5;
    bus.id_rs1 = 5'd5; bus.id_rs1_used = 1;
  endtask

  initial begin
    // Reset with a branch and a forwarding match present: reset outputs win.
    idle();
    reset = 1'b1;
    bus.br_taken = 1; bus.ex_rs1 = 5'd7; bus.mem_rd = 5'd7; bus.mem_wen = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_ctl", ctl, C_RST);
      chk("rst_fwd", fa, 8'd0);
      chk("rst_stall", stc, 8'd0);
      chk("rst_flush", flc, 8'd0);
    end
    reset = 1'b0;
    idle();
    #1 chk("run_ctl", ctl, C_RUN);
    tick();
    chk("run_stall", stc, 8'd0);

    // Load-use on rs1: two bubble cycles, then run.
    load_use();
    #1 chk("lu_c1", ctl, C_LU);
    tick();
    chk("lu_c2", ctl, C_LU);
    tick();
    idle();
    #1 chk("lu_done", ctl, C_RUN);
    chk("lu_stall", stc, 8'd2);
    // Unused source never hazards.
    load_use();
    bus.id_rs1_used = 0;
    #1 chk("lu_unused", ctl, C_RUN);

    // Forwarding priority.
    tick();
    idle();
    bus.ex_rs1 = 5'd7; bus.ex_rs2 = 5'd7; bus.mem_rd = 5'd7; bus.wb_rd = 5'd7;
    bus.mem_wen = 1; bus.wb_wen = 1;
    #1 chk("fwd_a_mem", fa, FWD ? 8'd2 : 8'd0);
    chk("fwd_b_mem", fb, FWD ? 8'd2 : 8'd0);
    bus.mem_wen = 0;
    #1 chk("fwd_a_wb", fa, FWD ? 8'd1 : 8'd0);
    bus.mem_wen = 1; bus.mem_rd = 5'd9;
    #1 chk("fwd_a_wb2", fa, FWD ? 8'd1 : 8'd0);
    bus.ex_rs1 = 5'd0; bus.mem_rd = 5'd0;
    #1 chk("fwd_a_x0", fa, 8'd0);

    // Branch during a load-use stall: stall aborted, two flush cycles.
    tick();
    do_reset();
    load_use();
    #1 chk("bl_lu", ctl, C_LU);
    tick();
    bus.br_taken = 1;
    #1 chk("bl_br", ctl, C_BR);
    tick();
    idle();
    #1 chk("bl_flush", ctl, C_BR);
    tick();
    chk("bl_run", ctl, C_RUN);
    chk("bl_stall", stc, 8'd1);
    chk("bl_flcnt", flc, 8'd2);

    // Branch inside the flush window reloads it.
    bus.br_taken = 1;
    #1 chk("rl_br1", ctl, C_BR);
    tick();
    chk("rl_br2", ctl, C_BR);
    tick();
    bus.br_taken = 0;
    #1 chk("rl_win", ctl, C_BR);
    tick();
    chk("rl_run", ctl, C_RUN);
    chk("rl_flcnt", flc, 8'd5);

    // Multi-cycle unit busy for four cycles.
    do_reset();
    bus.mc_busy = 1;
    for (int i = 0; i < 4; i++) begin
      #1 chk("mc_busy", ctl, C_MC);
      tick();
    end
    bus.mc_busy = 0;
    #1 chk("mc_resume", ctl, C_RUN);
    chk("mc_stall", stc, 8'd4);
    chk("mc_flcnt", flc, 8'd0);

    // Release cycle is re-evaluated: pending load-use takes effect at once.
    tick();
    bus.mc_busy = 1;
    tick();
    bus.mc_busy = 0;
    load_use();
    #1 chk("mc_lu", ctl, C_LU);
    tick();
    chk("mc_lu2", ctl, C_LU);
    tick();
    idle();
    #1 chk("mc_lu_run", ctl, C_RUN);

    // Counter saturation at 4'hF.
    do_reset();
    bus.mc_busy = 1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      chk("sat", stc, 8'(i < 15 ? i : 15));
    end
    bus.mc_busy = 0;

    // Non-load producers: stall only when forwarding is built out.
    do_reset();
    bus.ex_wen = 1; bus.ex_rd = 5'd3; bus.id_rs2 = 5'd3; bus.id_rs2_used = 1;
    bus.ex_rs2 = 5'd3; bus.wb_rd = 5'd3; bus.wb_wen = 1;
    #1 chk("alu_ctl", ctl, FWD ? C_RUN : C_LU);
    chk("alu_fwd_b", fb, FWD ? 8'd1 : 8'd0);
    bus.ex_wen = 0;
    #1 chk("wb_only", ctl, C_RUN);
    bus.mem_rd = 5'd3; bus.mem_wen = 1;
    #1 chk("mem_hit", ctl, FWD ? C_RUN : C_LU);
    bus.id_rs2_used = 0;
    #1 chk("mem_unused", ctl, C_RUN);
    idle();
    bus.ex_wen = 1; bus.ex_is_load = 1; bus.ex_rd = 5'd0;
    bus.id_rs1 = 5'd0; bus.id_rs1_used = 1;
    #1 chk("x0_load", ctl, C_RUN);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
